fir_tap_sequencer: RTL and testbench
====================================

// Module: fir_tap_sequencer
// PURPOSE
//   Sequencer for the FIR datapath. Accepts one audio sample per valid/ready handshake.
//   Stores it in a TAPS-deep circular delay line.
//   Then drives the shared MAC for TAPS consecutive cycles, issuing one coefficient/sample pair per cycle.
//   Captures the accumulated result and presents it as one filtered output sample.
// PARAMETERS
//   TAPS    8   number of filter taps / delay-line depth (2..16)
//   DATA_W  21  sample and coefficient width (fixed-point fraction)
//   ACC_W   25  MAC accumulator / output width
// PORTS
//   clk           in   1       system clock, rising edge
//   reset         in   1       asynchronous, active-low reset (0 = reset)
//   sample_in     in   DATA_W  new input sample
//   sample_valid  in   1       sample_in valid; held by source until accepted
//   sample_ready  out  1       sequencer can accept a sample this cycle
//   coef_addr     out  4       coefficient ROM address (combinational ROM, same-cycle coef_in)
//   coef_in       in   DATA_W  coefficient at coef_addr
//   mac_a         out  DATA_W  MAC operand A (= coef_in)
//   mac_b         out  DATA_W  MAC operand B (delay-line sample)
//   mac_en        out  1       MAC accumulates a*b at this rising edge
//   mac_first     out  1       with mac_en: MAC loads a*b instead of acc + a*b
//   mac_acc       in   ACC_W   MAC registered accumulator
//   y_out         out  ACC_W   last filtered output, held until next result
//   y_valid       out  1       one-cycle pulse: y_out updated
//   busy          out  1       high in RUN and DRAIN
// BEHAVIOUR
//   Reset (reset=0, async):
//     - delay line all 0, wr_ptr=0, k=0, state=IDLE.
//     - y_out=0, y_valid=0, mac_en=0, mac_first=0.
//     - sample_ready=1 once reset is released.
//   FSM states: IDLE, RUN, DRAIN.
//   IDLE: sample_ready=1, busy=0, mac_en=0, coef_addr=0.
//     On an edge with sample_valid=1 (accept edge E0):
//       - buf[wr_ptr]<=sample_in, head<=wr_ptr.
//       - wr_ptr<=(wr_ptr==TAPS-1)?0:wr_ptr+1 (wrap).
//       - k<=0, state<=RUN.
//   RUN: sample_ready=0, mac_en=1, mac_first=(k==0), coef_addr=k, mac_a=coef_in.
//     - mac_b=buf[(head-k) mod TAPS]: newest sample pairs with coef 0, oldest with coef TAPS-1.
//     - k increments each edge.
//     - On the edge where k==TAPS-1: state<=DRAIN.
//   DRAIN: mac_en=0; mac_acc holds the full sum.
//     - At the DRAIN edge: y_out<=mac_acc, y_valid<=1 for one cycle, state<=IDLE.
//   Timing:
//     - RUN occupies edges E0+1..E0+TAPS.
//     - y_valid is high in the cycle after edge E0+TAPS+1.
//     - Next accept is possible at E0+TAPS+2 earliest.
//     - Throughput: 1 sample / (TAPS+2) clocks.
//   Handshake:
//     - Transfer only when sample_valid & sample_ready at a rising edge.
//     - sample_valid while busy is ignored: no write, no pointer move. The source must hold.
//     - A sample presented in the same cycle y_valid pulses is accepted (state is IDLE).
//   Arithmetic:
//     - No arithmetic in this block; all products and sums are in the MAC.
//     - Pointer subtraction is modulo TAPS, also for non-power-of-two TAPS.
//   Outputs when not in RUN: mac_a and mac_b are don't-care; mac_first=0.
//   Reset mid-RUN/DRAIN:
//     - Immediate abort, no y_valid.
//     - Delay line is cleared (all reset values above re-apply).
// TESTING
//   1 Reset/idle:
//     - reset=0 mid-RUN (k=3) -> y_valid never pulses; all outputs at reset values.
//     - Next sample -> mac_b for k=1..7 = 0.
//   2 Impulse:
//     - coef ROM c[k]=k+1; sample 100 then seven 0s; bench MAC model.
//     - For output n=0..7: exactly one mac_en cycle has mac_b=100, at coef_addr=n.
//   3 Timing:
//     - Accept at E0 -> mac_en high for exactly 8 cycles, mac_first only on the first.
//     - y_valid single pulse after E0+9; sample_ready low from E0+1 to E0+9.
//   4 Wrap-around:
//     - 10 samples 1..10 -> on 10th output, mac_b sequence by k = 10,9,8,7,6,5,4,3.
//   5 Backpressure:
//     - sample_valid held high continuously with new data each accept -> accepts exactly every 10 clocks.
//     - No sample lost or duplicated (check mac_b at k=0).
//   6 Back-to-back: sample presented in the y_valid cycle -> accepted that edge; y_out unchanged until its own DRAIN.

Source files
------------

// File: rtl/fir_tap_sequencer_if.sv
// Sample handshake, MAC operand bus and result signals of the FIR tap sequencer.
//   sample_in/sample_valid/sample_ready : input sample valid/ready handshake
//   coef_addr/coef_in                   : combinational coefficient ROM lookup
//   mac_a/mac_b/mac_en/mac_first        : operands and controls for the shared MAC
//   mac_acc                             : registered MAC accumulator
//   y_out/y_valid                       : filtered output and its one-cycle strobe
//   busy                                : sequencer is running or draining the MAC
// Modport master is the sequencer side; slave is the source/ROM/MAC/sink side.
interface fir_tap_sequencer_if #(
    parameter int unsigned DATA_W = 21,
    parameter int unsigned ACC_W  = 25
);
    logic [DATA_W-1:0] sample_in;
    logic              sample_valid;
    logic              sample_ready;
    logic [3:0]        coef_addr;
    logic [DATA_W-1:0] coef_in;
    logic [DATA_W-1:0] mac_a;
    logic [DATA_W-1:0] mac_b;
    logic              mac_en;
    logic              mac_first;
    logic [ACC_W-1:0]  mac_acc;
    logic [ACC_W-1:0]  y_out;
    logic              y_valid;
    logic              busy;

    modport master (
        input  sample_in, sample_valid, coef_in, mac_acc,
        output sample_ready, coef_addr, mac_a, mac_b, mac_en, mac_first,
               y_out, y_valid, busy
    );

    modport slave (
        output sample_in, sample_valid, coef_in, mac_acc,
        input  sample_ready, coef_addr, mac_a, mac_b, mac_en, mac_first,
               y_out, y_valid, busy
    );
endinterface

// File: rtl/fir_tap_sequencer.sv
// FIR tap sequencer: accepts one sample per handshake into a TAPS-deep circular
// delay line, then steps the shared MAC through TAPS coefficient/sample pairs
// and captures the accumulated sum as one filtered output.
//   clk   : rising-edge clock
//   reset : asynchronous active-low reset
//   bus   : sample handshake, coefficient ROM, MAC operands and result (master side)
module fir_tap_sequencer #(
    parameter int unsigned TAPS   = 8,
    parameter int unsigned DATA_W = 21,
    parameter int unsigned ACC_W  = 25
) (
    input  logic                 clk,
    input  logic                 reset,
    fir_tap_sequencer_if.master  bus
);

    localparam int unsigned      IDX_W = (TAPS > 1) ? $clog2(TAPS) : 1;
    localparam int unsigned      SUM_W = IDX_W + 1;
    localparam logic [IDX_W-1:0] LAST  = IDX_W'(TAPS - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t            state;
    state_t            state_d;
    logic [DATA_W-1:0] dline [TAPS];
    logic [IDX_W-1:0]  wr_ptr;
    logic [IDX_W-1:0]  head;
    logic [IDX_W-1:0]  k;
    logic [IDX_W-1:0]  rd_idx_c;
    logic [ACC_W-1:0]  y_out_q;
    logic              y_valid_q;
    logic              accept_c;
    logic              run_c;
    logic              drain_c;

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_d;
        end
    end

    // Next state and state-decoded controls
    always_comb begin
        state_d          = state;
        accept_c         = 1'b0;
        run_c            = 1'b0;
        drain_c          = 1'b0;
        bus.sample_ready = 1'b0;
        bus.busy         = 1'b0;
        bus.mac_en       = 1'b0;
        bus.mac_first    = 1'b0;
        bus.coef_addr    = 4'd0;
        unique case (state)
            IDLE: begin
                bus.sample_ready = 1'b1;
                if (bus.sample_valid) begin
                    accept_c = 1'b1;
                    state_d  = RUN;
                end
            end
            RUN: begin
                run_c         = 1'b1;
                bus.busy      = 1'b1;
                bus.mac_en    = 1'b1;
                bus.mac_first = (k == '0);
                bus.coef_addr = 4'(k);
                if (k == LAST) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                drain_c  = 1'b1;
                bus.busy = 1'b1;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Delay line, pointers, tap counter and output capture
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int unsigned i = 0; i < TAPS; i++) begin
                dline[i] <= '0;
            end
            wr_ptr    <= '0;
            head      <= '0;
            k         <= '0;
            y_out_q   <= '0;
            y_valid_q <= 1'b0;
        end else begin
            y_valid_q <= 1'b0;
            if (accept_c) begin
                dline[wr_ptr] <= bus.sample_in;
                head          <= wr_ptr;
                wr_ptr        <= (wr_ptr == LAST) ? '0 : wr_ptr + 1'b1;
                k             <= '0;
            end
            // k returns to 0 on the last tap so it idles at 0 outside RUN
            if (run_c) begin
                k <= (k == LAST) ? '0 : k + 1'b1;
            end
            if (drain_c) begin
                y_out_q   <= bus.mac_acc;
                y_valid_q <= 1'b1;
            end
        end
    end

    // Tap k reads the sample k positions older than head, wrapping modulo TAPS
    always_comb begin
        if (head >= k) begin
            rd_idx_c = head - k;
        end else begin
            rd_idx_c = IDX_W'(SUM_W'(head) + SUM_W'(TAPS) - SUM_W'(k));
        end
    end

    assign bus.mac_a   = bus.coef_in;
    assign bus.mac_b   = dline[rd_idx_c];
    assign bus.y_out   = y_out_q;
    assign bus.y_valid = y_valid_q;

endmodule

// File: tb/tb_fir_tap_sequencer.sv
// Directed bench for fir_tap_sequencer: coefficient ROM c[k]=k+1, a behavioural
// MAC, and a history of accepted samples that gives the expected tap operands.
module tb_fir_tap_sequencer;

    localparam int TAPS   = 8;
    localparam int DATA_W = 21;
    localparam int ACC_W  = 25;

    logic clk = 1'b0;
    logic reset = 1'b0;

    always #5 clk = ~clk;

    fir_tap_sequencer_if #(.DATA_W(DATA_W), .ACC_W(ACC_W)) bus ();

    fir_tap_sequencer #(.TAPS(TAPS), .DATA_W(DATA_W), .ACC_W(ACC_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Coefficient ROM: c[k] = k + 1
    assign bus.coef_in = DATA_W'(bus.coef_addr) + DATA_W'(1);

    // Behavioural MAC with registered accumulator
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            bus.mac_acc <= '0;
        end else if (bus.mac_en) begin
            if (bus.mac_first) begin
                bus.mac_acc <= ACC_W'(longint'(bus.mac_a) * longint'(bus.mac_b));
            end else begin
                bus.mac_acc <= ACC_W'(longint'(bus.mac_acc) + longint'(bus.mac_a) * longint'(bus.mac_b));
            end
        end
    end

    int cyc = 0;
    always @(posedge clk) cyc++;

    int               total = 0;
    int               bad = 0;
    int               hist[$];
    int               last_mb[TAPS];
    int               acc_cyc = 0;
    int               prev_cyc = 0;
    logic [ACC_W-1:0] y_prev = '0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int exp_b(input int k);
        int n;
        n = hist.size() - 1 - k;
        return (n >= 0) ? hist[n] : 0;
    endfunction

    task automatic present(input int d);
        bus.sample_in    = DATA_W'(d);
        bus.sample_valid = 1'b1;
    endtask

    task automatic wait_accept(input string tag);
        bit done;
        done = 1'b0;
        for (int i = 0; i < 40 && !done; i++) begin
            if (bus.sample_ready === 1'b1) begin
                hist.push_back(int'(bus.sample_in));
                acc_cyc = cyc;
                done = 1'b1;
            end
            tick();
        end
        chk({tag, "_accept"}, 32'(done), 32'd1);
    endtask

    // Walks the RUN, DRAIN and result cycles after an accept edge
    task automatic watch_run(input bit hold, input int nxt, input string tag);
        int ysum;
        ysum = 0;
        if (hold) bus.sample_in = DATA_W'(nxt);
        else      bus.sample_valid = 1'b0;
        for (int k = 0; k < TAPS; k++) begin
            chk($sformatf("%s_en_k%0d", tag, k),    32'(bus.mac_en),       32'd1);
            chk($sformatf("%s_first_k%0d", tag, k), 32'(bus.mac_first),    32'(k == 0));
            chk($sformatf("%s_addr_k%0d", tag, k),  32'(bus.coef_addr),    32'(k));
            chk($sformatf("%s_maca_k%0d", tag, k),  32'(bus.mac_a),        32'(k + 1));
            chk($sformatf("%s_macb_k%0d", tag, k),  32'(bus.mac_b),        32'(exp_b(k)));
            chk($sformatf("%s_rdy_k%0d", tag, k),   32'(bus.sample_ready), 32'd0);
            chk($sformatf("%s_yv_k%0d", tag, k),    32'(bus.y_valid),      32'd0);
            chk($sformatf("%s_yhold_k%0d", tag, k), 32'(bus.y_out),        32'(y_prev));
            last_mb[k] = int'(bus.mac_b);
            ysum += (k + 1) * exp_b(k);
            tick();
        end
        chk({tag, "_drain_en"},    32'(bus.mac_en),       32'd0);
        chk({tag, "_drain_first"}, 32'(bus.mac_first),    32'd0);
        chk({tag, "_drain_busy"},  32'(bus.busy),         32'd1);
        chk({tag, "_drain_rdy"},   32'(bus.sample_ready), 32'd0);
        chk({tag, "_drain_yv"},    32'(bus.y_valid),      32'd0);
        chk({tag, "_drain_yhold"}, 32'(bus.y_out),        32'(y_prev));
        tick();
        chk({tag, "_yv"},   32'(bus.y_valid),      32'd1);
        chk({tag, "_y"},    32'(bus.y_out),        32'(ACC_W'(ysum)));
        chk({tag, "_rdy"},  32'(bus.sample_ready), 32'd1);
        chk({tag, "_busy"}, 32'(bus.busy),         32'd0);
        chk({tag, "_en"},   32'(bus.mac_en),       32'd0);
        y_prev = ACC_W'(ysum);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.sample_in    = '0;
        bus.sample_valid = 1'b0;

        // Reset state
        reset = 1'b0;
        tick();
        tick();
        chk("rst_y",     32'(bus.y_out),     32'd0);
        chk("rst_yv",    32'(bus.y_valid),   32'd0);
        chk("rst_en",    32'(bus.mac_en),    32'd0);
        chk("rst_first", 32'(bus.mac_first), 32'd0);
        chk("rst_busy",  32'(bus.busy),      32'd0);
        chk("rst_addr",  32'(bus.coef_addr), 32'd0);
        reset = 1'b1;
        tick();
        chk("idle_rdy",  32'(bus.sample_ready), 32'd1);

        // Impulse 100 followed by seven zeros: output n equals 100*(n+1)
        for (int n = 0; n < TAPS; n++) begin
            present((n == 0) ? 100 : 0);
            wait_accept($sformatf("imp%0d", n));
            watch_run(1'b0, 0, $sformatf("imp%0d", n));
            chk($sformatf("imp%0d_yconst", n), 32'(bus.y_out), 32'(100 * (n + 1)));
            chk($sformatf("imp%0d_pos", n), 32'(last_mb[n]), 32'd100);
        end

        // Reset asserted mid-RUN at k=3 aborts with no result
        present(77);
        wait_accept("abort");
        bus.sample_valid = 1'b0;
        tick();
        tick();
        tick();
        chk("abort_k3", 32'(bus.coef_addr), 32'd3);
        reset = 1'b0;
        #1;
        chk("abort_yv",    32'(bus.y_valid),   32'd0);
        chk("abort_y",     32'(bus.y_out),     32'd0);
        chk("abort_en",    32'(bus.mac_en),    32'd0);
        chk("abort_first", 32'(bus.mac_first), 32'd0);
        chk("abort_busy",  32'(bus.busy),      32'd0);
        chk("abort_addr",  32'(bus.coef_addr), 32'd0);
        tick();
        reset = 1'b1;
        hist.delete();
        y_prev = '0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk($sformatf("post_rst_yv%0d", i),  32'(bus.y_valid),      32'd0);
            chk($sformatf("post_rst_rdy%0d", i), 32'(bus.sample_ready), 32'd1);
        end

        // First sample after reset sees a cleared delay line
        present(5);
        wait_accept("clr");
        watch_run(1'b0, 0, "clr");
        for (int k = 1; k < TAPS; k++) begin
            chk($sformatf("clr_zero_k%0d", k), 32'(last_mb[k]), 32'd0);
        end
        chk("clr_yconst", 32'(bus.y_out), 32'd5);

        // Samples 1..10 with valid held high: accepts every TAPS+2 clocks,
        // each new sample taken in the cycle its predecessor's result appears
        present(1);
        for (int s = 1; s <= 10; s++) begin
            wait_accept($sformatf("bp%0d", s));
            if (s > 1) begin
                chk($sformatf("bp%0d_gap", s), 32'(acc_cyc - prev_cyc), 32'(TAPS + 2));
            end
            prev_cyc = acc_cyc;
            watch_run(s < 10, s + 1, $sformatf("bp%0d", s));
        end
        for (int k = 0; k < TAPS; k++) begin
            chk($sformatf("wrap_k%0d", k), 32'(last_mb[k]), 32'(10 - k));
        end
        chk("wrap_yconst", 32'(bus.y_out), 32'd192);
        tick();
        chk("wrap_yv_pulse", 32'(bus.y_valid), 32'd0);
        chk("wrap_yhold",    32'(bus.y_out),   32'd192);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
